// File: rtl/button_if_pkg.sv
// Shared definitions for the push-button peripheral: register offsets,
// the bridge's button window base and the debounce state encoding.
package button_if_pkg;

  localparam logic [1:0]  BTN_OFF_LEVEL = 2'd0;
  localparam logic [1:0]  BTN_OFF_EVENT = 2'd1;
  localparam logic [1:0]  BTN_OFF_COUNT = 2'd2;
  localparam logic [1:0]  BTN_OFF_RSVD  = 2'd3;

  localparam logic [31:0] BTN_BASE_ADDR = 32'hFFFF_F000;

  typedef enum logic [1:0] {
    DB_UP        = 2'd0,
    DB_WAIT_DOWN = 2'd1,
    DB_DOWN      = 2'd2,
    DB_WAIT_UP   = 2'd3
  } db_state_e;

  function automatic logic [1:0] btn_reg_offset(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/button_if_if.sv
// Bus port between the bridge (master) and the button peripheral (slave).
interface button_if_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/button_if_debounce_cell.sv
// One button: 2-flop synchroniser followed by a four-state debounce FSM
// that emits a clean level and a single-cycle pulse on each accepted press.
module btn_debounce_cell
  import button_if_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic press_pulse
);

  localparam int                 DB_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q;
  logic                s_in_q;
  db_state_e           state_q;
  logic [DB_CNT_W-1:0] cnt_q;
  logic                stable_q;
  logic                pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_in_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      s_in_q  <= sync1_q;
    end
  end

  // Any sample disagreeing with the candidate level drops back and restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DB_UP;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        DB_UP: begin
          if (s_in_q) begin
            state_q <= DB_WAIT_DOWN;
            cnt_q   <= CNT_ONE;
          end
        end
        DB_WAIT_DOWN: begin
          if (!s_in_q) begin
            state_q <= DB_UP;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q  <= DB_DOWN;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            pulse_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DB_DOWN: begin
          if (!s_in_q) begin
            state_q <= DB_WAIT_UP;
            cnt_q   <= CNT_ONE;
          end
        end
        DB_WAIT_UP: begin
          if (s_in_q) begin
            state_q <= DB_DOWN;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q  <= DB_UP;
            cnt_q    <= '0;
            stable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign stable      = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/button_if.sv
// Memory-mapped push-button peripheral: debounced levels, sticky W1C press
// events and a press counter, read back combinationally through the bridge.
module button_if
  import button_if_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  button,
  button_if_if.slave        bus,
  output logic              btn_event_any
);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] press_pulse;

  for (genvar g = 0; g < N_BTN; g++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (button[g]),
      .stable     (stable[g]),
      .press_pulse(press_pulse[g])
    );
  end

  logic [1:0]       off;
  logic             wr_event;
  logic             wr_count;
  logic [N_BTN-1:0] clr_mask;
  logic [CNT_W-1:0] press_cnt;
  logic [N_BTN-1:0] event_d, event_q;
  logic [CNT_W-1:0] count_d, count_q;

  assign off      = btn_reg_offset(bus.addr);
  assign wr_event = bus.we && (off == BTN_OFF_EVENT);
  assign wr_count = bus.we && (off == BTN_OFF_COUNT);
  assign clr_mask = wr_event ? bus.wdata[N_BTN-1:0] : '0;

  // New presses are applied after the clear so a same-cycle press always survives.
  always_comb begin
    press_cnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press_cnt = press_cnt + CNT_W'(press_pulse[i]);
    end
    event_d = (event_q & ~clr_mask) | press_pulse;
    count_d = (wr_count ? '0 : count_q) + press_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= '0;
      count_q <= '0;
    end else begin
      event_q <= event_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (off)
      BTN_OFF_LEVEL: bus.rdata[N_BTN-1:0] = stable;
      BTN_OFF_EVENT: bus.rdata[N_BTN-1:0] = event_q;
      BTN_OFF_COUNT: bus.rdata[CNT_W-1:0] = count_q;
      default:       bus.rdata = '0;
    endcase
  end

  assign btn_event_any = |event_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:N_BTN]};

endmodule

// File: tb/tb_button_if.sv
// Bench for button_if: directed scenarios plus randomized button/bus traffic
// compared against a run-length behavioural model of the debounced buttons.
`timescale 1ns/1ps
module tb_button_if;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] button = '0;
  logic         evt_any;
  int           errors = 0;
  int           checks = 0;

  button_if_if bus();

  button_if #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .bus          (bus),
    .btn_event_any(evt_any)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with the current level for D consecutive samples.
  logic [N-1:0]  m_sync1, m_sync2, m_stable, m_pulse, m_event, m_newp, m_clr;
  logic [CW-1:0] m_count;
  int            m_run [N];
  logic          preset_en = 1'b0;
  logic [CW-1:0] preset_val = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_pulse = '0;
      m_event = '0; m_count = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      if (preset_en) m_count = preset_val;
      m_clr   = (bus.we && bus.addr[3:2] == 2'd1) ? bus.wdata[N-1:0] : '0;
      m_event = (m_event & ~m_clr) | m_pulse;
      if (bus.we && bus.addr[3:2] == 2'd2) m_count = '0;
      m_count = m_count + CW'($countones(m_pulse));
      m_newp  = '0;
      for (int i = 0; i < N; i++) begin
        if (m_sync2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_stable[i] = m_sync2[i];
            m_run[i]    = 0;
            m_newp[i]   = m_sync2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pulse = m_newp;
      m_sync2 = m_sync1;
      m_sync1 = button;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] off);
    case (off)
      2'd0:    return 32'(m_stable);
      2'd1:    return 32'(m_event);
      2'd2:    return 32'(m_count);
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] v);
    bus.we   = 1'b0;
    bus.addr = {28'h0, off, 2'b00};
    #1;
    v = bus.rdata;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    bus.addr  = {28'h0, off, 2'b00};
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic press(input logic [N-1:0] mask);
    button = mask;
    tick(6);
    button = '0;
    tick(8);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; button = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    for (int o = 0; o < 4; o++) begin
      rd(2'(o), v);
      checks++;
      if (v !== 32'h0) begin $display("FAIL reset_off%0d: got %h want %h", o, v, 32'h0); errors++; end
    end
    checks++;
    if (evt_any !== 1'b0) begin $display("FAIL reset_evt_any: got %b want 0", evt_any); errors++; end
  endtask

  task automatic test_bounce();
    logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      button[0] = 1'b1; tick(2);
      button[0] = 1'b0; tick(2);
    end
    for (int k = 0; k < 8; k++) begin
      rd(2'd0, v);
      checks++;
      if (v !== 32'h0) begin $display("FAIL bounce_level: got %h want %h", v, 32'h0); errors++; end
      tick(1);
    end
    rd(2'd1, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL bounce_event: got %h want %h", v, 32'h0); errors++; end
    rd(2'd2, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL bounce_count: got %h want %h", v, 32'h0); errors++; end
  endtask

  task automatic test_clean_press();
    logic [31:0] v;
    button[2] = 1'b1;
    tick(5);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL press_level_early: got %h want %h", v, 32'h0); errors++; end
    tick(1);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h4) begin $display("FAIL press_level: got %h want %h", v, 32'h4); errors++; end
    tick(1);
    rd(2'd1, v);
    checks++;
    if (v !== 32'h4) begin $display("FAIL press_event: got %h want %h", v, 32'h4); errors++; end
    rd(2'd2, v);
    checks++;
    if (v !== 32'h1) begin $display("FAIL press_count: got %h want %h", v, 32'h1); errors++; end
    checks++;
    if (evt_any !== 1'b1) begin $display("FAIL press_evt_any: got %b want 1", evt_any); errors++; end
    tick(13);
    button[2] = 1'b0;
    tick(6);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL release_level: got %h want %h", v, 32'h0); errors++; end
    rd(2'd1, v);
    checks++;
    if (v !== 32'h4) begin $display("FAIL release_event: got %h want %h", v, 32'h4); errors++; end
    rd(2'd2, v);
    checks++;
    if (v !== 32'h1) begin $display("FAIL release_count: got %h want %h", v, 32'h1); errors++; end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    wr(2'd1, 32'h1F);
    checks++;
    if (evt_any !== 1'b0) begin $display("FAIL w1c_clear_all: got %b want 0", evt_any); errors++; end
    press(5'h05);
    rd(2'd1, v);
    checks++;
    if (v !== 32'h5) begin $display("FAIL w1c_preset: got %h want %h", v, 32'h5); errors++; end
    wr(2'd1, 32'h1);
    rd(2'd1, v);
    checks++;
    if (v !== 32'h4) begin $display("FAIL w1c_clear_bit0: got %h want %h", v, 32'h4); errors++; end
    button[2] = 1'b1;
    tick(6);
    wr(2'd1, 32'h4);
    rd(2'd1, v);
    checks++;
    if (v !== 32'h4) begin $display("FAIL w1c_set_wins: got %h want %h", v, 32'h4); errors++; end
    button[2] = 1'b0;
    tick(8);
    wr(2'd1, 32'h4);
    rd(2'd1, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL w1c_clear_bit2: got %h want %h", v, 32'h0); errors++; end
    checks++;
    if (evt_any !== 1'b0) begin $display("FAIL w1c_evt_any: got %b want 0", evt_any); errors++; end
    wr(2'd0, 32'h1F);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL level_write_ignored: got %h want %h", v, 32'h0); errors++; end
  endtask

  task automatic test_counter();
    logic [31:0] v;
    wr(2'd2, 32'h0);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL count_clear: got %h want %h", v, 32'h0); errors++; end
    press(5'h0A);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h2) begin $display("FAIL count_pair: got %h want %h", v, 32'h2); errors++; end
    button = 5'h02;
    tick(6);
    wr(2'd2, 32'h0);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h1) begin $display("FAIL count_write_press: got %h want %h", v, 32'h1); errors++; end
    button = '0;
    tick(8);
    force dut.count_q = 16'hFFFF;
    preset_val = 16'hFFFF;
    preset_en  = 1'b1;
    #1;
    release dut.count_q;
    @(negedge clk);
    preset_en = 1'b0;
    rd(2'd2, v);
    checks++;
    if (v !== 32'hFFFF) begin $display("FAIL count_preset: got %h want %h", v, 32'hFFFF); errors++; end
    press(5'h01);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL count_wrap: got %h want %h", v, 32'h0); errors++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    button = 5'h10;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL rstmid_level_early: got %h want %h", v, 32'h0); errors++; end
    rd(2'd3, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL rstmid_rsvd: got %h want %h", v, 32'h0); errors++; end
    tick(1);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h10) begin $display("FAIL rstmid_level: got %h want %h", v, 32'h10); errors++; end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    checks++;
    if (v !== 32'h0) begin $display("FAIL rsvd_write: got %h want %h", v, 32'h0); errors++; end
    button = '0;
    tick(8);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] e;
    for (int c = 0; c < 600; c++) begin
      for (int o = 0; o < 4; o++) begin
        rd(2'(o), v);
        e = model_rd(2'(o));
        checks++;
        if (v !== e) begin $display("FAIL rand_off%0d cyc%0d: got %h want %h", o, c, v, e); errors++; end
      end
      checks++;
      if (evt_any !== (|m_event)) begin
        $display("FAIL rand_evt_any cyc%0d: got %b want %b", c, evt_any, |m_event); errors++;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) button[i] = ~button[i];
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.addr  = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
        bus.wdata = $urandom;
        bus.we    = 1'b1;
      end
      @(negedge clk);
      bus.we = 1'b0;
    end
    button = '0;
    tick(10);
  endtask

  initial begin
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_w1c();
    test_counter();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
